// File: rtl/archie_kbd.sv
// Archimedes keyboard controller: IOC serial-byte handshake, key event FIFO,
// identity and LED commands, with a minimum gap between transmitted bytes.
module archie_kbd #(
    parameter logic [5:0]  KBD_ID = 6'h01,
    parameter int unsigned TX_GAP = 16
) (
    input  logic       clkcpu,
    input  logic       rst_n,
    input  logic [7:0] host_data,
    input  logic       host_strobe,
    output logic [7:0] kbd_data,
    output logic       kbd_strobe,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       key_up,
    output logic       key_ready,
    output logic [2:0] leds
);

    localparam int unsigned GAP_W   = $clog2(TX_GAP + 1);
    localparam int unsigned FIFO_D  = 4;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned CNT_W   = 3;

    typedef enum logic [3:0] {
        S_HRST, W_HRST, S_RAK1, W_RAK1, S_RAK2, W_RAK2,
        IDLE, S_ID, S_B1, W_BACK, S_B2, W_ACK
    } state_t;

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_q;
    logic [8:0]         fifo_mem [FIFO_D];
    logic [PTR_W-1:0]   wr_q, rd_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               key_en_q, key_en_d;
    logic [2:0]         leds_d;
    logic               pend_v;
    logic [7:0]         pend_q;
    logic [8:0]         cur_q;
    logic [8:0]         head;

    logic               can_tx, tx, pop, push, flush, consume, load_cur, is_ack;
    logic [7:0]         tx_byte;

    // Key report byte: 0xC0 for press, 0xD0 for release, low nibble row or column
    function automatic logic [7:0] key_byte(input logic up, input logic [3:0] nib);
        return {3'b110, up, nib};
    endfunction

    assign head   = fifo_mem[rd_q];
    assign can_tx = (gap_q == '0) && !host_strobe;
    assign is_ack = (pend_q[7:2] == 6'b001100);

    // Next-state, transmit and bookkeeping decisions
    always_comb begin
        state_d  = state_q;
        tx       = 1'b0;
        tx_byte  = 8'h00;
        pop      = 1'b0;
        flush    = 1'b0;
        consume  = 1'b0;
        load_cur = 1'b0;
        key_en_d = key_en_q;
        leds_d   = leds;
        push     = 1'b0;
        count_d  = count_q;

        case (state_q)
            S_HRST: if (can_tx) begin tx = 1'b1; tx_byte = 8'hFF; state_d = W_HRST; end
            S_RAK1: if (can_tx) begin tx = 1'b1; tx_byte = 8'hFE; state_d = W_RAK1; end
            S_RAK2: if (can_tx) begin tx = 1'b1; tx_byte = 8'hFD; state_d = W_RAK2; end
            S_ID:   if (can_tx) begin tx = 1'b1; tx_byte = {2'b10, KBD_ID}; state_d = IDLE; end
            S_B1: if (can_tx) begin
                tx       = 1'b1;
                tx_byte  = key_byte(head[8], head[7:4]);
                pop      = 1'b1;
                load_cur = 1'b1;
                state_d  = W_BACK;
            end
            S_B2: if (can_tx) begin
                tx      = 1'b1;
                tx_byte = key_byte(cur_q[8], cur_q[3:0]);
                state_d = W_ACK;
            end
            W_HRST: if (pend_v) begin
                consume = 1'b1;
                if (pend_q == 8'hFF) state_d = S_RAK1;
            end
            W_RAK1, W_RAK2, W_BACK, W_ACK: if (pend_v) begin
                consume = 1'b1;
                if (pend_q == 8'hFF) begin
                    flush   = 1'b1;
                    state_d = S_RAK1;
                end else begin
                    state_d = S_HRST;
                    if (state_q == W_RAK1 && pend_q == 8'hFE) state_d = S_RAK2;
                    if (state_q == W_RAK2 && pend_q == 8'hFD) state_d = IDLE;
                    if (state_q == W_BACK && pend_q == 8'h3F) state_d = S_B2;
                    if (state_q == W_ACK && is_ack) begin
                        key_en_d = pend_q[0];
                        state_d  = IDLE;
                    end
                end
            end
            IDLE: if (pend_v) begin
                consume = 1'b1;
                if (pend_q == 8'hFF) begin
                    flush   = 1'b1;
                    state_d = S_RAK1;
                end else if (is_ack) begin
                    key_en_d = pend_q[0];
                end else if (pend_q == 8'h20) begin
                    state_d = S_ID;
                end else if (pend_q[7:3] == 5'b00000) begin
                    leds_d = pend_q[2:0];
                end
            end else if (key_en_q && count_q != '0) begin
                state_d = S_B1;
            end
            default: state_d = S_HRST;
        endcase

        // A host reset drops keyboard enables, LEDs and any queued events
        if (flush) begin
            key_en_d = 1'b0;
            leds_d   = 3'b000;
            count_d  = '0;
        end else begin
            push    = key_valid && key_ready;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State register
    always_ff @(posedge clkcpu) begin
        if (!rst_n) state_q <= S_HRST;
        else        state_q <= state_d;
    end

    // Datapath: gap counter, output byte, host latch, FIFO pointers, enables
    always_ff @(posedge clkcpu) begin
        if (!rst_n) begin
            gap_q      <= GAP_W'(TX_GAP);
            kbd_data   <= 8'h00;
            kbd_strobe <= 1'b0;
            pend_v     <= 1'b0;
            pend_q     <= 8'h00;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            key_ready  <= 1'b1;
            key_en_q   <= 1'b0;
            leds       <= 3'b000;
            cur_q      <= 9'h000;
        end else begin
            if (host_strobe || tx)  gap_q <= GAP_W'(TX_GAP);
            else if (gap_q != '0)   gap_q <= gap_q - GAP_W'(1);

            kbd_strobe <= tx;
            if (tx) kbd_data <= tx_byte;

            if (host_strobe) begin
                pend_v <= 1'b1;
                pend_q <= host_data;
            end else if (consume) begin
                pend_v <= 1'b0;
            end

            if (flush) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + PTR_W'(1);
                if (pop)  rd_q <= rd_q + PTR_W'(1);
            end
            count_q   <= count_d;
            key_ready <= (count_d != CNT_W'(FIFO_D));
            key_en_q  <= key_en_d;
            leds      <= leds_d;
            if (load_cur) cur_q <= head;
        end
    end

    // Event storage; contents are don't-care until written
    always_ff @(posedge clkcpu) begin
        if (push) fifo_mem[wr_q] <= {key_up, key_code};
    end

endmodule

// File: tb/tb_archie_kbd.sv
// Directed bench for archie_kbd: handshake/command table plus key-pair sequences.
module tb_archie_kbd;

    localparam int unsigned TX_GAP = 16;

    logic       clkcpu = 1'b0;
    logic       rst_n;
    logic [7:0] host_data;
    logic       host_strobe;
    logic [7:0] kbd_data;
    logic       kbd_strobe;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_up;
    logic       key_ready;
    logic [2:0] leds;

    always #5 clkcpu = ~clkcpu;

    archie_kbd #(.KBD_ID(6'h01), .TX_GAP(TX_GAP)) dut (
        .clkcpu(clkcpu), .rst_n(rst_n),
        .host_data(host_data), .host_strobe(host_strobe),
        .kbd_data(kbd_data), .kbd_strobe(kbd_strobe),
        .key_valid(key_valid), .key_code(key_code), .key_up(key_up),
        .key_ready(key_ready), .leds(leds)
    );

    typedef struct { logic [7:0] data; int at; } rx_t;
    typedef struct { logic [7:0] host; logic rep; logic [7:0] data; logic [2:0] leds; } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_any = -1000;
    rx_t  rx_q[$];

    // Capture every transmitted byte and check spacing from the previous strobe
    always @(negedge clkcpu) begin
        cyc = cyc + 1;
        if (kbd_strobe) begin
            checks++;
            if (cyc - last_any < int'(TX_GAP)) begin
                failures++;
                $display("FAIL strobe_gap actual=%0d required>=%0d", cyc - last_any, TX_GAP);
            end
            last_any = cyc;
            rx_q.push_back('{kbd_data, cyc});
        end
        if (host_strobe) last_any = cyc;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_host(input logic [7:0] b);
        @(posedge clkcpu); #1;
        host_data   = b;
        host_strobe = 1'b1;
        @(posedge clkcpu); #1;
        host_strobe = 1'b0;
    endtask

    task automatic push_key(input logic [7:0] code, input logic up);
        @(posedge clkcpu); #1;
        key_code  = code;
        key_up    = up;
        key_valid = 1'b1;
        @(posedge clkcpu); #1;
        key_valid = 1'b0;
    endtask

    task automatic expect_reply(input string name, input logic [7:0] exp, output int at);
        rx_t r;
        int  n = 0;
        at = -1;
        while (rx_q.size() == 0 && n < 80) begin
            @(negedge clkcpu); #1;
            n++;
        end
        if (rx_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s actual=timeout required=%0h", name, exp);
        end else begin
            r  = rx_q.pop_front();
            at = r.at;
            check(name, 32'(r.data), 32'(exp));
        end
    endtask

    task automatic expect_none(input string name);
        repeat (TX_GAP + 10) @(negedge clkcpu);
        #1;
        check(name, 32'(rx_q.size()), 32'd0);
        rx_q.delete();
    endtask

    task automatic reply(input string name, input logic [7:0] exp);
        int at;
        expect_reply(name, exp, at);
    endtask

    task automatic release_and_check_ff(input string name);
        int rel, at;
        @(posedge clkcpu); #1;
        rst_n = 1'b1;
        rel   = cyc;
        expect_reply(name, 8'hFF, at);
        check({name, "_lat"}, 32'((at - rel >= int'(TX_GAP) + 1) && (at - rel <= int'(TX_GAP) + 2)), 32'd1);
    endtask

    vec_t tbl[9];

    initial begin
        rst_n       = 1'b0;
        host_data   = 8'h00;
        host_strobe = 1'b0;
        key_valid   = 1'b0;
        key_code    = 8'h00;
        key_up      = 1'b0;

        // Reset values
        repeat (3) @(posedge clkcpu);
        #1;
        check("rst_strobe", 32'(kbd_strobe), 32'd0);
        check("rst_data",   32'(kbd_data),   32'h00);
        check("rst_ready",  32'(key_ready),  32'd1);
        check("rst_leds",   32'(leds),       32'd0);

        release_and_check_ff("hrst_ff");

        // Handshake and IDLE command table
        tbl[0] = '{8'hFF, 1'b1, 8'hFE, 3'd0};
        tbl[1] = '{8'hFE, 1'b1, 8'hFD, 3'd0};
        tbl[2] = '{8'hFD, 1'b0, 8'h00, 3'd0};
        tbl[3] = '{8'h20, 1'b1, 8'h81, 3'd0};
        tbl[4] = '{8'h05, 1'b0, 8'h00, 3'd5};
        tbl[5] = '{8'h07, 1'b0, 8'h00, 3'd7};
        tbl[6] = '{8'h55, 1'b0, 8'h00, 3'd7};
        tbl[7] = '{8'h08, 1'b0, 8'h00, 3'd7};
        tbl[8] = '{8'h02, 1'b0, 8'h00, 3'd2};
        for (int i = 0; i < 9; i++) begin
            send_host(tbl[i].host);
            if (tbl[i].rep) reply($sformatf("tbl%0d_reply", i), tbl[i].data);
            else            expect_none($sformatf("tbl%0d_quiet", i));
            check($sformatf("tbl%0d_leds", i), 32'(leds), 32'(tbl[i].leds));
        end

        // Single key press pair with SACK
        send_host(8'h31);
        expect_none("sack_quiet");
        push_key(8'h34, 1'b0);
        reply("key_row", 8'hC3);
        send_host(8'h3F);
        reply("key_col", 8'hC4);
        send_host(8'h31);
        expect_none("after_ack_quiet");
        check("after_ack_ready", 32'(key_ready), 32'd1);

        // Disabled keyboard fills the FIFO, then reports in order once enabled
        send_host(8'h30);
        expect_none("nack_quiet");
        push_key(8'h12, 1'b0);
        push_key(8'h23, 1'b1);
        push_key(8'h45, 1'b0);
        check("fifo3_ready", 32'(key_ready), 32'd1);
        push_key(8'h67, 1'b1);
        check("fifo4_ready", 32'(key_ready), 32'd0);
        push_key(8'h7A, 1'b0);
        check("fifo5_ready", 32'(key_ready), 32'd0);
        expect_none("disabled_quiet");
        send_host(8'h33);
        reply("ev1_row", 8'hC1);
        check("pop_ready", 32'(key_ready), 32'd1);
        send_host(8'h3F); reply("ev1_col", 8'hC2);
        send_host(8'h31); reply("ev2_row", 8'hD2);
        send_host(8'h3F); reply("ev2_col", 8'hD3);
        send_host(8'h33); reply("ev3_row", 8'hC4);
        send_host(8'h3F); reply("ev3_col", 8'hC5);
        send_host(8'h31); reply("ev4_row", 8'hD6);
        send_host(8'h3F); reply("ev4_col", 8'hD7);
        send_host(8'h31);
        expect_none("ev5_dropped");

        // Wrong byte in W_BACK forces a keyboard reset
        push_key(8'h58, 1'b0);
        reply("bad_back_row", 8'hC5);
        send_host(8'h31);
        reply("bad_back_hrst", 8'hFF);
        send_host(8'hFF); reply("rehs_fe", 8'hFE);
        send_host(8'hFE); reply("rehs_fd", 8'hFD);
        send_host(8'hFD); expect_none("rehs_quiet");

        // Host reset mid-transfer flushes the FIFO and clears LEDs/enables
        send_host(8'h06); expect_none("leds6_quiet");
        send_host(8'h31); expect_none("en_quiet");
        push_key(8'h9B, 1'b0);
        reply("flush_row", 8'hC9);
        push_key(8'hAC, 1'b0);
        send_host(8'hFF);
        reply("flush_fe", 8'hFE);
        check("flush_leds", 32'(leds), 32'd0);
        check("flush_ready", 32'(key_ready), 32'd1);
        send_host(8'hFE); reply("flush_fd", 8'hFD);
        send_host(8'hFD); expect_none("flush_idle");
        send_host(8'h31);
        expect_none("flush_empty");

        // Reset in the middle of a byte pair
        send_host(8'h06); expect_none("leds6b_quiet");
        check("leds6", 32'(leds), 32'd6);
        push_key(8'h34, 1'b1);
        reply("mid_row", 8'hD3);
        push_key(8'h11, 1'b0);
        @(posedge clkcpu); #1;
        rst_n = 1'b0;
        @(posedge clkcpu); #1;
        check("mid_rst_strobe", 32'(kbd_strobe), 32'd0);
        check("mid_rst_data",   32'(kbd_data),   32'h00);
        check("mid_rst_leds",   32'(leds),       32'd0);
        check("mid_rst_ready",  32'(key_ready),  32'd1);
        release_and_check_ff("mid_hrst_ff");
        send_host(8'hFF); reply("mid_fe", 8'hFE);
        send_host(8'hFE); reply("mid_fd", 8'hFD);
        send_host(8'hFD); expect_none("mid_idle");
        send_host(8'h31);
        expect_none("mid_fifo_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
